// File: rtl/and_sweep_pkg.sv
// rtl/and_sweep_pkg.sv - shared types, constants and expected-output function for the AND sweep checker
package and_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  localparam int VEC_W   = 2;
  localparam int NUM_VEC = 4;

  // Golden AND response for a {a,b} vector
  function automatic logic and_expect(input logic [VEC_W-1:0] vec);
    return vec[1] & vec[0];
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - loadable settle down-counter that flags when the hold window has elapsed
module sweep_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload wins; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/and_sweep_checker.sv
// rtl/and_sweep_checker.sv - on-chip exhaustive stimulus/response checker for a 2-input AND gate
module and_sweep_checker
  import and_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int N_PASSES      = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             c_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam int TW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int PW = (N_PASSES < 2) ? 1 : $clog2(N_PASSES + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES);
  localparam logic [PW-1:0]    LAST_PASS   = PW'(N_PASSES - 1);

  sweep_state_t     state_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] vec_d;
  logic [PW-1:0]    pcnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             fv_q;
  logic [1:0]       fvec_q;
  logic             a_q;
  logic             b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic start_run;
  logic sample;
  logic mismatch;
  logic last_vec;
  logic run_end;
  logic timer_zero;

  // Sample/compare decode and saturating error next-value
  always_comb begin
    start_run = start && (state_q != RUN);
    sample    = (state_q == RUN) && timer_zero;
    mismatch  = sample && (c_i != and_expect(vec_q));
    vec_d     = vec_q + 1'b1;
    last_vec  = (vec_q == VEC_W'(NUM_VEC - 1));
    run_end   = last_vec && (pcnt_q == LAST_PASS);
    err_d     = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  sweep_settle_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_run || sample),
    .load_val (SETTLE_LOAD),
    .zero     (timer_zero)
  );

  // Sweep FSM with vector/pass counters, error count and first-fail capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= 2'b00;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            vec_q   <= '0;
            pcnt_q  <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= 2'b00;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        RUN: begin
          err_q <= err_d;
          if (mismatch && !fv_q) begin
            fv_q   <= 1'b1;
            fvec_q <= vec_q;
          end
          if (sample) begin
            if (run_end) begin
              state_q <= DONE;
              vec_q   <= '0;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_d;
              a_q   <= vec_d[1];
              b_q   <= vec_d[0];
              if (last_vec) begin
                pcnt_q <= pcnt_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_and_sweep_checker.sv
// tb/tb_and_sweep_checker.sv - randomized self-checking bench for and_sweep_checker
module tb_and_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Three instances cover different parameter sets: A(1,1,8) B(1,3,8) C(2,4,2)
  int s_tab[3] = '{1, 1, 2};
  int n_tab[3] = '{1, 3, 4};
  int m_tab[3] = '{255, 255, 3};

  logic [2:0] start_v = 3'b000;
  logic [2:0] a_v, b_v, c_v, busy_v, done_v, pass_v, fv_v;
  logic [1:0] fvec0, fvec1, fvec2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [3:0] tt[3];

  // Gate under test modelled as a truth table indexed by {a,b}
  assign c_v[0] = tt[0][{a_v[0], b_v[0]}];
  assign c_v[1] = tt[1][{a_v[1], b_v[1]}];
  assign c_v[2] = tt[2][{a_v[2], b_v[2]}];

  and_sweep_checker #(.SETTLE_CYCLES(1), .N_PASSES(1), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_o(a_v[0]), .b_o(b_v[0]), .c_i(c_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err0),
    .fail_valid(fv_v[0]), .fail_vec(fvec0));
  and_sweep_checker #(.SETTLE_CYCLES(1), .N_PASSES(3), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_o(a_v[1]), .b_o(b_v[1]), .c_i(c_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1),
    .fail_valid(fv_v[1]), .fail_vec(fvec1));
  and_sweep_checker #(.SETTLE_CYCLES(2), .N_PASSES(4), .ERR_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_o(a_v[2]), .b_o(b_v[2]), .c_i(c_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err2),
    .fail_valid(fv_v[2]), .fail_vec(fvec2));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] get_err(input int i);
    return (i == 0) ? 32'(err0) : (i == 1) ? 32'(err1) : 32'(err2);
  endfunction

  function automatic logic [1:0] get_fvec(input int i);
    return (i == 0) ? fvec0 : (i == 1) ? fvec1 : fvec2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk every pass and vector, compare the table against a&b
  task automatic model(input int i, input logic [3:0] tbl, output int err, output bit fv,
                       output logic [1:0] fvec);
    err  = 0;
    fv   = 1'b0;
    fvec = 2'b00;
    for (int p = 0; p < n_tab[i]; p++) begin
      for (int v = 0; v < 4; v++) begin
        logic [1:0] vb;
        vb = v[1:0];
        if (tbl[v] != (vb[1] & vb[0])) begin
          if (err < m_tab[i]) err++;
          if (!fv) begin
            fv   = 1'b1;
            fvec = vb;
          end
        end
      end
    end
  endtask

  task automatic run_sweep(input int i, input logic [3:0] tbl, input bit hold);
    int per, len, e_err;
    bit e_fv;
    logic [1:0] e_fvec;
    per = s_tab[i] + 1;
    len = 4 * n_tab[i] * per;
    tt[i] = tbl;
    model(i, tbl, e_err, e_fv, e_fvec);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    if (!hold) start_v[i] = 1'b0;
    for (int c = 0; c < len; c++) begin
      int v;
      v = (c / per) % 4;
      check_eq($sformatf("vec%0d_c%0d", i, c), {30'd0, a_v[i], b_v[i]}, 32'(v));
      check_eq($sformatf("busy%0d_c%0d", i, c), busy_v[i], 1);
      if (c == 0) check_eq($sformatf("done_clr%0d", i), done_v[i], 0);
      @(negedge clk);
    end
    check_eq($sformatf("done%0d", i), done_v[i], 1);
    check_eq($sformatf("busy_end%0d", i), busy_v[i], 0);
    check_eq($sformatf("err%0d_t%0h", i, tbl), get_err(i), 32'(e_err));
    check_eq($sformatf("pass%0d", i), pass_v[i], (e_err == 0) ? 1 : 0);
    check_eq($sformatf("fv%0d", i), fv_v[i], 32'(e_fv));
    check_eq($sformatf("fvec%0d", i), get_fvec(i), e_fvec);
    check_eq($sformatf("ab_idle%0d", i), {a_v[i], b_v[i]}, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tt[0] = 4'b1000;
    tt[1] = 4'b1000;
    tt[2] = 4'b1000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_busy", busy_v[i], 0);
      check_eq("rst_done", done_v[i], 0);
      check_eq("rst_pass", pass_v[i], 0);
      check_eq("rst_err", get_err(i), 0);
      check_eq("rst_fv", fv_v[i], 0);
      check_eq("rst_ab", {a_v[i], b_v[i]}, 0);
    end
    rst_n = 1'b1;

    // Directed cases: real AND, OR fault, stuck-at-0, saturating OR
    run_sweep(0, 4'b1000, 1'b0);
    run_sweep(0, 4'b1110, 1'b0);
    run_sweep(1, 4'b0000, 1'b0);
    run_sweep(2, 4'b1110, 1'b0);

    // Random gate tables on random instances
    for (int r = 0; r < 8; r++) begin
      int i;
      i = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep(i, 4'($urandom), 1'b0);
    end

    // Asynchronous reset mid-run on a table that mismatches at 00
    tt[0] = 4'b0001;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_err", err0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy_v[0], 0);
    check_eq("mid_rst_ab", {a_v[0], b_v[0]}, 0);
    check_eq("mid_rst_err", err0, 0);
    check_eq("mid_rst_fv", fv_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_done_c%0d", c), done_v[0], 0);
      check_eq($sformatf("post_rst_busy_c%0d", c), busy_v[0], 0);
    end

    // Start held high: no restart while busy, restart one cycle after done
    run_sweep(0, 4'b1110, 1'b1);
    @(negedge clk);
    check_eq("rerun_busy", busy_v[0], 1);
    check_eq("rerun_done", done_v[0], 0);
    check_eq("rerun_err", err0, 0);
    check_eq("rerun_fv", fv_v[0], 0);
    check_eq("rerun_ab", {a_v[0], b_v[0]}, 0);
    start_v[0] = 1'b0;
    pulse_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
